multicycle_step_ctrl: RTL
=========================

// Module: multicycle_step_ctrl
// PURPOSE
//  Multi-cycle sequencer for the NPC core. Replaces the combinational one-instruction-per-cycle top.
//  Holds the PC and the latched instruction, and drives valid/ready instruction and data buses.
//  Steps each instruction through FETCH/EXEC/MEM/WB. Performs load/store lane alignment and
//  load sign/zero extension. Decode, ALU and regfile remain external; this block sequences them.
// PARAMETERS
//  XLEN     32             datapath/address width (32 or 64)
//  INIT_PC  'h8000_0000    PC value after reset
// PORTS
//  clk            in   1     clock
//  reset          in   1     synchronous, active-high
//  ifu_req_valid  out  1     instruction fetch request valid
//  ifu_req_ready  in   1     fetch request accepted
//  ifu_addr       out  XLEN  fetch address (= pc)
//  ifu_rvalid     in   1     fetch response valid
//  ifu_rdata      in   32    fetched instruction
//  pc             out  XLEN  current PC
//  inst           out  32    latched instruction, stable from EXEC through WB
//  ex_next_pc     in   XLEN  next PC from datapath, sampled in EXEC
//  ex_is_load     in   1     decoded load, sampled in EXEC
//  ex_is_store    in   1     decoded store, sampled in EXEC
//  ex_funct3      in   3     access size/sign: 0=B 1=H 2=W 4=BU 5=HU (3=D/6=WU when XLEN=64)
//  ex_addr        in   XLEN  effective address (ALU out)
//  ex_wdata       in   XLEN  rs2 store data
//  dmem_req_valid out  1     data request valid
//  dmem_req_ready in   1     data request accepted
//  dmem_we        out  1     1=store
//  dmem_addr      out  XLEN  address, low log2(XLEN/8) bits forced to 0
//  dmem_wdata     out  XLEN  store data shifted to byte lane
//  dmem_wstrb     out  XLEN/8  byte strobes; 0 on loads
//  dmem_rvalid    in   1     data response valid (loads and stores)
//  dmem_rdata     in   XLEN  raw load word
//  rf_wen         out  1     one-cycle register write-enable pulse in WB
//  load_data      out  XLEN  aligned, extended load result, valid while rf_wen=1
//  commit         out  1     one-cycle pulse per retired instruction
//  misalign       out  1     sticky; set on misaligned access, core halts
// BEHAVIOUR
//  - Reset: state=FETCH_REQ, pc=INIT_PC, inst=0. All valids, rf_wen, commit, misalign and wstrb = 0.
//  - FETCH_REQ: ifu_req_valid=1. Holds until ifu_req_ready, then goes to FETCH_WAIT.
//  - FETCH_WAIT: on ifu_rvalid, inst<=ifu_rdata, then go to EXEC. Fetch rvalid in the same cycle as ready is not accepted.
//  - EXEC (1 cycle): latch ex_* into internal registers.
//    - Misaligned access (H with addr[0]!=0, W with addr[1:0]!=0, D with addr[2:0]!=0): go to HALT, misalign<=1.
//    - Load or store: go to MEM_REQ.
//    - Otherwise: go to WB.
//  - MEM_REQ: dmem_req_valid=1. Address, data and strobe stay stable until dmem_req_ready, then go to MEM_WAIT.
//  - MEM_WAIT: wait for dmem_rvalid, capture rdata, then go to WB.
//  - WB (1 cycle): commit=1. rf_wen=1 unless store. pc<=latched next_pc. Then go to FETCH_REQ.
//  - HALT: absorbing state; only reset exits. No bus requests are issued.
//  - Minimum latency, non-mem instruction: 4 cycles (FETCH_REQ, FETCH_WAIT, EXEC, WB) with zero-wait buses.
//  - Minimum latency, load/store: 6 cycles.
//  - Store lanes: wstrb = size mask << addr offset; wdata = ex_wdata << (8*offset).
//  - Load extraction: rdata >> (8*offset), truncated to size. BU/HU/WU zero-extend; others sign-extend.
//  - Unsupported funct3 on load/store is treated as W.
//  - pc/inst change only in WB/FETCH_WAIT. ifu_addr=pc at all times.
//  - Spurious ifu_rvalid/dmem_rvalid outside the WAIT states is ignored.
//  - Reset mid-transaction abandons it; in-flight responses after reset are ignored until a new request.
// CONFIGURATION
//  NPC_PERF_CNT_EN
//  - Defined: adds outputs perf_cycle[63:0] and perf_instret[63:0].
//    - perf_cycle increments every non-reset cycle, including HALT.
//    - perf_instret increments on commit.
//    - Both clear on reset and wrap modulo 2^64.
//  - Undefined: ports and counters are absent.
// TESTING
//  1. Reset, ready=1, rvalid next cycle, inst=addi, next_pc=pc+4 -> commit every 4 cycles; pc 0x80000000, 0x80000004, ...
//  2. lb at addr 0x80000003, rdata=0x80xxxxxx -> dmem_addr=0x80000000, wstrb=0, load_data=0xFFFFFF80, rf_wen=1.
//  3. sh at 0x80000002, rs2=0x1234 -> wstrb=4'b1100, wdata=0x12340000, rf_wen=0, commit=1.
//  4. lw at 0x80000001 -> misalign=1, HALT; no further ifu_req_valid; reset restores pc=INIT_PC.
//  5. ifu_req_ready held low 5 cycles, then dmem_rvalid delayed 3 cycles -> requests held stable, single commit.
//  6. With NPC_PERF_CNT_EN, 10 addi -> perf_instret=10, perf_cycle=40 at 10th commit (zero-wait buses).

Source files
------------

// File: rtl/multicycle_step_ctrl_if.sv
// Instruction-fetch and data-memory valid/ready buses between the step sequencer and its memories.
interface multicycle_step_ctrl_if #(
  parameter int XLEN = 32
);
  logic              ifu_req_valid;
  logic              ifu_req_ready;
  logic [XLEN-1:0]   ifu_addr;
  logic              ifu_rvalid;
  logic [31:0]       ifu_rdata;

  logic              dmem_req_valid;
  logic              dmem_req_ready;
  logic              dmem_we;
  logic [XLEN-1:0]   dmem_addr;
  logic [XLEN-1:0]   dmem_wdata;
  logic [XLEN/8-1:0] dmem_wstrb;
  logic              dmem_rvalid;
  logic [XLEN-1:0]   dmem_rdata;

  modport master (
    output ifu_req_valid, ifu_addr,
    input  ifu_req_ready, ifu_rvalid, ifu_rdata,
    output dmem_req_valid, dmem_we, dmem_addr, dmem_wdata, dmem_wstrb,
    input  dmem_req_ready, dmem_rvalid, dmem_rdata
  );

  modport slave (
    input  ifu_req_valid, ifu_addr,
    output ifu_req_ready, ifu_rvalid, ifu_rdata,
    input  dmem_req_valid, dmem_we, dmem_addr, dmem_wdata, dmem_wstrb,
    output dmem_req_ready, dmem_rvalid, dmem_rdata
  );
endinterface

// File: rtl/multicycle_step_ctrl.sv
// Multi-cycle FETCH/EXEC/MEM/WB sequencer with load/store lane alignment and load extension.
// Optional NPC_PERF_CNT_EN adds 64-bit cycle and retired-instruction counters.
module multicycle_step_ctrl #(
  parameter int              XLEN    = 32,
  parameter logic [XLEN-1:0] INIT_PC = XLEN'(32'h8000_0000)
) (
  input  logic                       clk,
  input  logic                       reset,
  multicycle_step_ctrl_if.master     bus,
  output logic [XLEN-1:0]            pc,
  output logic [31:0]                inst,
  input  logic [XLEN-1:0]            ex_next_pc,
  input  logic                       ex_is_load,
  input  logic                       ex_is_store,
  input  logic [2:0]                 ex_funct3,
  input  logic [XLEN-1:0]            ex_addr,
  input  logic [XLEN-1:0]            ex_wdata,
  output logic                       rf_wen,
  output logic [XLEN-1:0]            load_data,
  output logic                       commit,
  output logic                       misalign
`ifdef NPC_PERF_CNT_EN
  ,
  output logic [63:0]                perf_cycle,
  output logic [63:0]                perf_instret
`endif
);

  localparam int NB   = XLEN / 8;
  localparam int OFFW = $clog2(NB);

  typedef enum logic [2:0] {
    S_FETCH_REQ, S_FETCH_WAIT, S_EXEC, S_MEM_REQ, S_MEM_WAIT, S_WB, S_HALT
  } state_e;

  // Returns {unsigned, log2(bytes)}; unsupported encodings fall back to a signed word.
  function automatic logic [2:0] decode_size(input logic [2:0] f3);
    logic [2:0] r;
    case (f3)
      3'd0:    r = 3'b0_00;
      3'd1:    r = 3'b0_01;
      3'd2:    r = 3'b0_10;
      3'd4:    r = 3'b1_00;
      3'd5:    r = 3'b1_01;
      3'd3:    r = (XLEN == 64) ? 3'b0_11 : 3'b0_10;
      3'd6:    r = (XLEN == 64) ? 3'b1_10 : 3'b0_10;
      default: r = 3'b0_10;
    endcase
    return r;
  endfunction

  state_e          state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [31:0]     inst_q, inst_d;
  logic [XLEN-1:0] next_pc_q, next_pc_d;
  logic            store_q, store_d;
  logic [1:0]      size_q, size_d;
  logic            uns_q, uns_d;
  logic [XLEN-1:0] addr_q, addr_d;
  logic [XLEN-1:0] wdata_q, wdata_d;
  logic [XLEN-1:0] rdata_q, rdata_d;
  logic            misalign_q, misalign_d;

  logic [2:0]      ex_sz;
  logic            ex_misalign;
  logic            ex_mem;

  always_comb begin
    ex_sz  = decode_size(ex_funct3);
    ex_mem = ex_is_load | ex_is_store;
    case (ex_sz[1:0])
      2'd1:    ex_misalign = ex_addr[0];
      2'd2:    ex_misalign = |ex_addr[1:0];
      2'd3:    ex_misalign = |ex_addr[2:0];
      default: ex_misalign = 1'b0;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    inst_d     = inst_q;
    next_pc_d  = next_pc_q;
    store_d    = store_q;
    size_d     = size_q;
    uns_d      = uns_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    rdata_d    = rdata_q;
    misalign_d = misalign_q;
    bus.ifu_req_valid  = 1'b0;
    bus.dmem_req_valid = 1'b0;
    commit             = 1'b0;
    rf_wen             = 1'b0;

    case (state_q)
      S_FETCH_REQ: begin
        bus.ifu_req_valid = 1'b1;
        if (bus.ifu_req_ready) state_d = S_FETCH_WAIT;
      end
      S_FETCH_WAIT: begin
        if (bus.ifu_rvalid) begin
          inst_d  = bus.ifu_rdata;
          state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        next_pc_d = ex_next_pc;
        store_d   = ex_is_store;
        size_d    = ex_sz[1:0];
        uns_d     = ex_sz[2];
        addr_d    = ex_addr;
        wdata_d   = ex_wdata;
        if (ex_mem && ex_misalign) begin
          misalign_d = 1'b1;
          state_d    = S_HALT;
        end else if (ex_mem) begin
          state_d = S_MEM_REQ;
        end else begin
          state_d = S_WB;
        end
      end
      S_MEM_REQ: begin
        bus.dmem_req_valid = 1'b1;
        if (bus.dmem_req_ready) state_d = S_MEM_WAIT;
      end
      S_MEM_WAIT: begin
        if (bus.dmem_rvalid) begin
          rdata_d = bus.dmem_rdata;
          state_d = S_WB;
        end
      end
      S_WB: begin
        commit  = 1'b1;
        rf_wen  = ~store_q;
        pc_d    = next_pc_q;
        state_d = S_FETCH_REQ;
      end
      S_HALT:  state_d = S_HALT;
      default: state_d = S_FETCH_REQ;
    endcase

    // Keep every request and pulse quiet while reset is held.
    if (reset) begin
      bus.ifu_req_valid  = 1'b0;
      bus.dmem_req_valid = 1'b0;
      commit             = 1'b0;
      rf_wen             = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_FETCH_REQ;
      pc_q       <= INIT_PC;
      inst_q     <= '0;
      next_pc_q  <= '0;
      store_q    <= 1'b0;
      size_q     <= '0;
      uns_q      <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      rdata_q    <= '0;
      misalign_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      inst_q     <= inst_d;
      next_pc_q  <= next_pc_d;
      store_q    <= store_d;
      size_q     <= size_d;
      uns_q      <= uns_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      rdata_q    <= rdata_d;
      misalign_q <= misalign_d;
    end
  end

  logic [OFFW-1:0] offset;
  logic [NB-1:0]   size_mask;
  logic [XLEN-1:0] shifted;

  always_comb begin
    offset = addr_q[OFFW-1:0];
    case (size_q)
      2'd0:    size_mask = NB'(8'h01);
      2'd1:    size_mask = NB'(8'h03);
      2'd2:    size_mask = NB'(8'h0F);
      default: size_mask = NB'(8'hFF);
    endcase
    shifted = rdata_q >> {offset, 3'b000};
    case (size_q)
      2'd0:    load_data = uns_q ? XLEN'(shifted[7:0])  : XLEN'(signed'(shifted[7:0]));
      2'd1:    load_data = uns_q ? XLEN'(shifted[15:0]) : XLEN'(signed'(shifted[15:0]));
      2'd2:    load_data = uns_q ? XLEN'(shifted[31:0]) : XLEN'(signed'(shifted[31:0]));
      default: load_data = shifted;
    endcase
  end

  assign bus.ifu_addr   = pc_q;
  assign bus.dmem_we    = store_q;
  assign bus.dmem_addr  = {addr_q[XLEN-1:OFFW], {OFFW{1'b0}}};
  assign bus.dmem_wdata = wdata_q << {offset, 3'b000};
  assign bus.dmem_wstrb = (state_q == S_MEM_REQ && store_q && !reset) ? (size_mask << offset) : '0;

  assign pc       = pc_q;
  assign inst     = inst_q;
  assign misalign = misalign_q;

`ifdef NPC_PERF_CNT_EN
  logic [63:0] perf_cycle_q, perf_cycle_d;
  logic [63:0] perf_instret_q, perf_instret_d;

  always_comb begin
    perf_cycle_d   = perf_cycle_q + 64'd1;
    perf_instret_d = perf_instret_q + {63'd0, commit};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      perf_cycle_q   <= '0;
      perf_instret_q <= '0;
    end else begin
      perf_cycle_q   <= perf_cycle_d;
      perf_instret_q <= perf_instret_d;
    end
  end

  assign perf_cycle   = perf_cycle_q;
  assign perf_instret = perf_instret_q;
`endif

endmodule
